// File: rtl/up_packet_interface_pkg.sv
// up_packet_interface_pkg: shared types and default sizes for the uP packet interface.
//   byte_t   - one bus byte
//   state_t  - transaction FSM states
//   DEF_*    - default packet sizes and wait-state timeout
//   max_int  - integer maximum, used to size the shared byte counter
package up_packet_interface_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_H1_HI,
      S_RX_H1_LO,
      S_DISPATCH,
      S_WAIT_REPLY,
      S_TX_H1_HI,
      S_TX_H1_LO,
      S_ACK
   } state_t;
   localparam int DEF_NOS_WRITE_BYTES = 6;
   localparam int DEF_NOS_READ_BYTES = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   function automatic int max_int(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/up_packet_interface_if.sv
// up_packet_interface_if: uP pad bus plus packet hand-off signals.
//   master : drives the async uP controls, uP_data_in, tx_packet, tx_valid
//   slave  : the packet block; drives uP_data_out/oe, uP_handshake_2, uP_ack, rx_packet, rx_valid
interface up_packet_interface_if import up_packet_interface_pkg::*; #(
   parameter int NOS_WRITE_BYTES = DEF_NOS_WRITE_BYTES,
   parameter int NOS_READ_BYTES = DEF_NOS_READ_BYTES
);
   logic async_uP_start;
   logic async_uP_handshake_1;
   logic async_uP_RW;
   byte_t uP_data_in;
   byte_t uP_data_out;
   logic uP_data_oe;
   logic uP_handshake_2;
   logic uP_ack;
   logic [NOS_WRITE_BYTES*8-1:0] rx_packet;
   logic rx_valid;
   logic [NOS_READ_BYTES*8-1:0] tx_packet;
   logic tx_valid;
   modport master (
      output async_uP_start, async_uP_handshake_1, async_uP_RW, uP_data_in, tx_packet, tx_valid,
      input uP_data_out, uP_data_oe, uP_handshake_2, uP_ack, rx_packet, rx_valid
   );
   modport slave (
      input async_uP_start, async_uP_handshake_1, async_uP_RW, uP_data_in, tx_packet, tx_valid,
      output uP_data_out, uP_data_oe, uP_handshake_2, uP_ack, rx_packet, rx_valid
   );
endinterface

// File: rtl/up_packet_interface_sync.sv
// up_packet_interface_sync: W-bit two-flop synchroniser into the clk domain.
//   clk, reset (sync, active-low) ; d - async inputs ; q - synchronised outputs
module up_packet_interface_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= '0;
         q <= '0;
      end else begin
         meta <= d;
         q <= meta;
      end
   end
endmodule

// File: rtl/up_packet_interface.sv
// up_packet_interface: byte-wise handshaked command/reply packet transfer with a uP.
//   clk, reset (sync, active-low)
//   bus         - slave side of up_packet_interface_if (uP pad bus, rx/tx packets)
//   timeout_err - sticky, set when a wait state exceeds TIMEOUT_CYCLES, cleared by start
//   busy        - FSM not idle
module up_packet_interface import up_packet_interface_pkg::*; #(
   parameter int NOS_WRITE_BYTES = DEF_NOS_WRITE_BYTES,
   parameter int NOS_READ_BYTES = DEF_NOS_READ_BYTES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   up_packet_interface_if.slave bus,
   output logic timeout_err,
   output logic busy
);
   localparam int CW = $clog2(max_int(NOS_WRITE_BYTES, NOS_READ_BYTES) + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [TW-1:0] cyc;
   byte_t rx_buf [NOS_WRITE_BYTES];
   byte_t tx_buf [NOS_READ_BYTES];
   logic [NOS_WRITE_BYTES*8-1:0] rx_pkt;
   byte_t tx_byte;
   logic start_s, h1_s, rw_s, start_d;
   logic start_edge, waiting, tmo, rx_done;

   up_packet_interface_sync #(.W(3)) u_sync (
      .clk(clk),
      .reset(reset),
      .d({bus.async_uP_start, bus.async_uP_handshake_1, bus.async_uP_RW}),
      .q({start_s, h1_s, rw_s})
   );

   assign start_edge = start_s & ~start_d;
   assign waiting = state != S_IDLE && state != S_ACK;
   // a start edge in the same cycle as a timeout takes priority
   assign tmo = waiting && cyc == TW'(TIMEOUT_CYCLES - 1) && !start_edge;

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      rx_done = 1'b0;
      if (start_edge) begin
         state_n = S_RX_H1_HI;
         cnt_n = '0;
      end else if (tmo) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_RX_H1_HI: if (h1_s && rw_s) state_n = S_RX_H1_LO;
            S_RX_H1_LO: if (!h1_s) begin
               cnt_n = cnt + CW'(1);
               rx_done = cnt_n == CW'(NOS_WRITE_BYTES);
               state_n = rx_done ? S_DISPATCH : S_RX_H1_HI;
            end
            S_DISPATCH: state_n = S_WAIT_REPLY;
            S_WAIT_REPLY: if (bus.tx_valid) begin
               state_n = S_TX_H1_HI;
               cnt_n = '0;
            end
            S_TX_H1_HI: if (h1_s) state_n = S_TX_H1_LO;
            S_TX_H1_LO: if (!h1_s) begin
               cnt_n = cnt + CW'(1);
               state_n = cnt_n == CW'(NOS_READ_BYTES) ? S_ACK : S_TX_H1_HI;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      tx_byte = '0;
      for (int i = 0; i < NOS_READ_BYTES; i++) if (cnt == CW'(i)) tx_byte = tx_buf[i];
   end

   // rx_pkt is only refreshed on a complete packet, so aborted or timed-out
   // partial packets never become visible on rx_packet
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
         cyc <= '0;
         start_d <= 1'b0;
         timeout_err <= 1'b0;
         rx_buf <= '{default: '0};
         tx_buf <= '{default: '0};
         rx_pkt <= '0;
      end else begin
         cnt <= cnt_n;
         start_d <= start_s;
         cyc <= (state_n != state || start_edge) ? '0 :
                (cyc == TW'(TIMEOUT_CYCLES - 1)) ? cyc : cyc + TW'(1);
         timeout_err <= start_edge ? 1'b0 : (tmo ? 1'b1 : timeout_err);
         if (state == S_RX_H1_HI && state_n == S_RX_H1_LO)
            for (int i = 0; i < NOS_WRITE_BYTES; i++) if (cnt == CW'(i)) rx_buf[i] <= bus.uP_data_in;
         if (rx_done)
            for (int i = 0; i < NOS_WRITE_BYTES; i++) rx_pkt[i*8 +: 8] <= rx_buf[i];
         if (state == S_WAIT_REPLY && state_n == S_TX_H1_HI)
            for (int i = 0; i < NOS_READ_BYTES; i++) tx_buf[i] <= bus.tx_packet[i*8 +: 8];
      end
   end

   assign busy = state != S_IDLE;
   assign bus.uP_handshake_2 = state == S_RX_H1_LO || state == S_TX_H1_HI;
   // the pad is only driven while the uP has released the bus
   assign bus.uP_data_oe = state == S_TX_H1_HI && !rw_s;
   assign bus.uP_data_out = state == S_TX_H1_HI ? tx_byte : '0;
   assign bus.uP_ack = state == S_ACK;
   assign bus.rx_valid = state == S_DISPATCH;
   assign bus.rx_packet = rx_pkt;
endmodule

// File: tb/tb_up_packet_interface.sv
// tb_up_packet_interface: directed self-checking bench for up_packet_interface (6/8 and 2/4 byte instances).
module tb_up_packet_interface;
   import up_packet_interface_pkg::*;
   logic clk = 0, reset = 0, start = 0, h1 = 0, rw = 0, tx_valid = 0;
   byte_t din = '0;
   logic [63:0] txp0 = '0;
   logic [31:0] txp1 = '0;
   logic terr0, busy0, terr1, busy1;
   int checks = 0, errors = 0, rxv0 = 0, rxv1 = 0;

   always #5 clk = ~clk;

   up_packet_interface_if #(.NOS_WRITE_BYTES(6), .NOS_READ_BYTES(8)) if0 ();
   up_packet_interface_if #(.NOS_WRITE_BYTES(2), .NOS_READ_BYTES(4)) if1 ();

   assign if0.async_uP_start = start;
   assign if0.async_uP_handshake_1 = h1;
   assign if0.async_uP_RW = rw;
   assign if0.uP_data_in = din;
   assign if0.tx_packet = txp0;
   assign if0.tx_valid = tx_valid;
   assign if1.async_uP_start = start;
   assign if1.async_uP_handshake_1 = h1;
   assign if1.async_uP_RW = rw;
   assign if1.uP_data_in = din;
   assign if1.tx_packet = txp1;
   assign if1.tx_valid = tx_valid;

   up_packet_interface #(.NOS_WRITE_BYTES(6), .NOS_READ_BYTES(8), .TIMEOUT_CYCLES(64)) dut0 (
      .clk(clk), .reset(reset), .bus(if0), .timeout_err(terr0), .busy(busy0));
   up_packet_interface #(.NOS_WRITE_BYTES(2), .NOS_READ_BYTES(4), .TIMEOUT_CYCLES(64)) dut1 (
      .clk(clk), .reset(reset), .bus(if1), .timeout_err(terr1), .busy(busy1));

   always @(negedge clk) begin
      if (if0.rx_valid) rxv0++;
      if (if1.rx_valid) rxv1++;
   end

   function automatic logic hs2(input int d);
      return d != 0 ? if1.uP_handshake_2 : if0.uP_handshake_2;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int d, input logic lvl);
      int n = 0;
      while (hs2(d) !== lvl && n < 200) begin
         tick(1);
         n++;
      end
      if (hs2(d) !== lvl) begin
         checks++;
         errors++;
         $display("FAIL wait_hs dut%0d: handshake_2 %b, required %b within 200 cycles", d, hs2(d), lvl);
      end
   endtask

   task automatic do_reset();
      reset = 0; start = 0; h1 = 0; rw = 0; tx_valid = 0; din = '0;
      tick(3);
      reset = 1;
      tick(1);
   endtask

   task automatic pulse_start();
      start = 1;
      tick(4);
      start = 0;
      tick(3);
   endtask

   task automatic write_byte(input int d, input byte_t b);
      din = b; rw = 1; h1 = 1;
      wait_hs(d, 1'b1);
      h1 = 0;
      wait_hs(d, 1'b0);
   endtask

   task automatic read_byte(input int d, output byte_t v, output logic oe);
      rw = 0;
      wait_hs(d, 1'b1);
      tick(3);
      v = d != 0 ? if1.uP_data_out : if0.uP_data_out;
      oe = d != 0 ? if1.uP_data_oe : if0.uP_data_oe;
      h1 = 1;
      wait_hs(d, 1'b0);
      h1 = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy0); end
      checks++; if (if0.uP_handshake_2 !== 1'b0) begin errors++; $display("FAIL reset_hs2: got %b, expected 0", if0.uP_handshake_2); end
      checks++; if (if0.uP_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, expected 0", if0.uP_ack); end
      checks++; if (if0.uP_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b, expected 0", if0.uP_data_oe); end
      checks++; if (if0.uP_data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h, expected 00", if0.uP_data_out); end
      checks++; if (if0.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rxv: got %b, expected 0", if0.rx_valid); end
      checks++; if (if0.rx_packet !== 48'h0) begin errors++; $display("FAIL reset_rxpkt: got %h, expected 0", if0.rx_packet); end
      checks++; if (terr0 !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b, expected 0", terr0); end
   endtask

   task automatic test_write_read();
      byte_t wr [6] = '{8'h01, 8'h40, 8'h78, 8'h56, 8'h34, 8'h12};
      byte_t exp [8] = '{8'hE8, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      byte_t v;
      logic oe;
      int base;
      do_reset();
      base = rxv0;
      pulse_start();
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, expected 1", busy0); end
      foreach (wr[i]) write_byte(0, wr[i]);
      tick(2);
      checks++; if (rxv0 - base !== 1) begin errors++; $display("FAIL wr_rxv_count: got %0d, expected 1", rxv0 - base); end
      checks++; if (if0.rx_packet !== 48'h1234_5678_4001) begin errors++; $display("FAIL wr_rxpkt: got %h, expected 123456784001", if0.rx_packet); end
      txp0 = 64'h0000_0000_0000_03E8;
      rw = 0;
      tx_valid = 1;
      wait_hs(0, 1'b1);
      tx_valid = 0;
      for (int i = 0; i < 8; i++) begin
         read_byte(0, v, oe);
         checks++; if (v !== exp[i]) begin errors++; $display("FAIL rd_byte%0d: got %h, expected %h", i, v, exp[i]); end
         checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rd_oe%0d: got %b, expected 1", i, oe); end
         if (i < 7) begin
            checks++; if (if0.uP_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack%0d: got %b, expected 0", i, if0.uP_ack); end
         end
      end
      tick(4);
      checks++; if (if0.uP_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b, expected 1", if0.uP_ack); end
      checks++; if (if0.uP_data_oe !== 1'b0) begin errors++; $display("FAIL rd_ack_oe: got %b, expected 0", if0.uP_data_oe); end
      tick(10);
      checks++; if (if0.uP_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_hold: got %b, expected 1", if0.uP_ack); end
      pulse_start();
      checks++; if (if0.uP_ack !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b, expected 0", if0.uP_ack); end
   endtask

   task automatic test_timeout();
      int base;
      do_reset();
      base = rxv0;
      pulse_start();
      write_byte(0, 8'h11);
      din = 8'h22; rw = 1; h1 = 1;
      wait_hs(0, 1'b1);
      tick(63);
      checks++; if (busy0 !== 1'b1 || if0.uP_handshake_2 !== 1'b1) begin errors++; $display("FAIL to_early: busy %b hs2 %b, expected 1 1", busy0, if0.uP_handshake_2); end
      tick(1);
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL to_idle: busy %b, expected 0", busy0); end
      checks++; if (terr0 !== 1'b1) begin errors++; $display("FAIL to_terr: got %b, expected 1", terr0); end
      checks++; if (if0.uP_handshake_2 !== 1'b0) begin errors++; $display("FAIL to_hs2: got %b, expected 0", if0.uP_handshake_2); end
      h1 = 0;
      tick(10);
      checks++; if (terr0 !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b, expected 1", terr0); end
      checks++; if (rxv0 - base !== 0) begin errors++; $display("FAIL to_rxv: got %0d, expected 0", rxv0 - base); end
      checks++; if (if0.rx_packet !== 48'h0) begin errors++; $display("FAIL to_rxpkt: got %h, expected 0", if0.rx_packet); end
      pulse_start();
      checks++; if (terr0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL to_restart: terr %b busy %b, expected 0 1", terr0, busy0); end
   endtask

   task automatic test_abort();
      int base;
      do_reset();
      base = rxv0;
      pulse_start();
      write_byte(0, 8'h11);
      write_byte(0, 8'h22);
      write_byte(0, 8'h33);
      pulse_start();
      checks++; if (busy0 !== 1'b1 || if0.uP_handshake_2 !== 1'b0) begin errors++; $display("FAIL ab_state: busy %b hs2 %b, expected 1 0", busy0, if0.uP_handshake_2); end
      for (int i = 0; i < 6; i++) write_byte(0, byte_t'(8'hAA + i));
      tick(2);
      checks++; if (rxv0 - base !== 1) begin errors++; $display("FAIL ab_rxv_count: got %0d, expected 1", rxv0 - base); end
      checks++; if (if0.rx_packet !== 48'hAFAE_ADAC_ABAA) begin errors++; $display("FAIL ab_rxpkt: got %h, expected afaeadacabaa", if0.rx_packet); end
   endtask

   task automatic test_small();
      byte_t exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      byte_t v;
      logic oe;
      int base;
      do_reset();
      base = rxv1;
      pulse_start();
      write_byte(1, 8'h5A);
      tick(2);
      checks++; if (rxv1 - base !== 0) begin errors++; $display("FAIL sm_rxv_early: got %0d, expected 0", rxv1 - base); end
      write_byte(1, 8'hA5);
      tick(2);
      checks++; if (rxv1 - base !== 1) begin errors++; $display("FAIL sm_rxv: got %0d, expected 1", rxv1 - base); end
      checks++; if (if1.rx_packet !== 16'hA55A) begin errors++; $display("FAIL sm_rxpkt: got %h, expected a55a", if1.rx_packet); end
      txp1 = 32'hDDCC_BBAA;
      rw = 0;
      tx_valid = 1;
      wait_hs(1, 1'b1);
      tx_valid = 0;
      for (int i = 0; i < 4; i++) begin
         read_byte(1, v, oe);
         checks++; if (v !== exp[i]) begin errors++; $display("FAIL sm_byte%0d: got %h, expected %h", i, v, exp[i]); end
         tick(4);
         checks++; if (if1.uP_ack !== (i == 3)) begin errors++; $display("FAIL sm_ack%0d: got %b, expected %b", i, if1.uP_ack, i == 3); end
      end
   endtask

   task automatic test_reset_mid_tx();
      do_reset();
      pulse_start();
      for (int i = 0; i < 6; i++) write_byte(0, byte_t'(i));
      txp0 = 64'h8877_6655_4433_2211;
      rw = 0;
      tx_valid = 1;
      wait_hs(0, 1'b1);
      tx_valid = 0;
      tick(3);
      checks++; if (if0.uP_data_oe !== 1'b1 || if0.uP_data_out !== 8'h11) begin errors++; $display("FAIL rm_pre: oe %b dout %h, expected 1 11", if0.uP_data_oe, if0.uP_data_out); end
      reset = 0;
      tick(1);
      checks++; if (if0.uP_data_oe !== 1'b0) begin errors++; $display("FAIL rm_oe: got %b, expected 0", if0.uP_data_oe); end
      checks++; if (if0.uP_handshake_2 !== 1'b0) begin errors++; $display("FAIL rm_hs2: got %b, expected 0", if0.uP_handshake_2); end
      checks++; if (if0.uP_ack !== 1'b0) begin errors++; $display("FAIL rm_ack: got %b, expected 0", if0.uP_ack); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b, expected 0", busy0); end
      reset = 1;
      tick(1);
   endtask

   task automatic test_rw_high_tx();
      do_reset();
      pulse_start();
      for (int i = 0; i < 6; i++) write_byte(0, byte_t'(8'h10 + i));
      txp0 = 64'h0102_0304_0506_0777;
      rw = 1;
      tx_valid = 1;
      wait_hs(0, 1'b1);
      tx_valid = 0;
      for (int i = 0; i < 10; i++) begin
         checks++; if (if0.uP_data_oe !== 1'b0) begin errors++; $display("FAIL rwh_oe%0d: got %b, expected 0", i, if0.uP_data_oe); end
         tick(1);
      end
      rw = 0;
      tick(3);
      checks++; if (if0.uP_data_oe !== 1'b1 || if0.uP_data_out !== 8'h77) begin errors++; $display("FAIL rwh_release: oe %b dout %h, expected 1 77", if0.uP_data_oe, if0.uP_data_out); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_timeout();
      test_abort();
      test_small();
      test_reset_mid_tx();
      test_rw_high_tx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/up_packet_interface.md
UP_PACKET_INTERFACE -- requirements
Module: uP_packet_interface

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
  NOS_WRITE_BYTES, 6, bytes per command packet from uP
  NOS_READ_BYTES, 8, bytes per reply packet to uP
  TIMEOUT_CYCLES, 1024, maximum clk cycles spent in any single wait state
REQ-002 Ports (one per line: name  direction  width  meaning) SHALL be:
  clk  in  1  system clock, single clock domain
  reset  in  1  synchronous, active-low reset
  async_uP_start  in  1  transaction start, asynchronous
  async_uP_handshake_1  in  1  uP strobe/acknowledge, asynchronous
  async_uP_RW  in  1  1 = uP driving bus, asynchronous
  uP_data_in  in  8  bus value from pad
  uP_data_out  out  8  bus value to pad
  uP_data_oe  out  1  pad output enable
  uP_handshake_2  out  1  block strobe/acknowledge
  uP_ack  out  1  transaction complete
  rx_packet  out  NOS_WRITE_BYTES*8  received command packet; byte 0 in [7:0]
  rx_valid  out  1  one-cycle pulse, rx_packet valid
  tx_packet  in  NOS_READ_BYTES*8  reply packet; byte 0 in [7:0]
  tx_valid  in  1  reply ready, sampled in S_WAIT_REPLY only
  timeout_err  out  1  sticky timeout flag
  busy  out  1  state != S_IDLE

Function
REQ-003 The three async inputs SHALL each pass through a 2-flop synchroniser; all FSM decisions SHALL use synchronised values only.
REQ-004 Start SHALL be detected as a rising edge of synchronised start.
REQ-005 FSM states SHALL be: S_IDLE, S_RX_H1_HI, S_RX_H1_LO, S_DISPATCH, S_WAIT_REPLY, S_TX_H1_HI, S_TX_H1_LO, S_ACK.
REQ-006 S_IDLE/S_ACK -> S_RX_H1_HI on start edge; byte counter := 0, uP_ack := 0, timeout_err := 0.
REQ-007 S_RX_H1_HI: on H1=1 and RW=1, latch uP_data_in into byte[counter], assert uP_handshake_2, -> S_RX_H1_LO.
REQ-008 S_RX_H1_LO: on H1=0, deassert uP_handshake_2; counter+1; if counter reached NOS_WRITE_BYTES -> S_DISPATCH, else -> S_RX_H1_HI.
REQ-009 S_DISPATCH SHALL last exactly one cycle, pulse rx_valid, -> S_WAIT_REPLY.
REQ-010 S_WAIT_REPLY: on tx_valid=1 capture tx_packet into an internal buffer, counter := 0, -> S_TX_H1_HI.
REQ-011 S_TX_H1_HI: uP_data_out = buffer byte[counter], uP_data_oe = 1 only while synchronised RW=0, uP_handshake_2 = 1; on H1=1 deassert uP_handshake_2 -> S_TX_H1_LO.
REQ-012 S_TX_H1_LO: on H1=0, counter+1; if counter reached NOS_READ_BYTES -> S_ACK, else -> S_TX_H1_HI.
REQ-013 S_ACK: uP_ack = 1 and held until next start edge or reset; uP_data_oe = 0.
REQ-014 Start edge in any state other than S_IDLE/S_ACK SHALL abort: counter := 0, handshake_2 := 0, oe := 0, -> S_RX_H1_HI; partial packet discarded, no rx_valid.
REQ-015 A cycle counter SHALL reset on every state change; reaching TIMEOUT_CYCLES in any state except S_IDLE/S_ACK SHALL force -> S_IDLE, set timeout_err, clear handshake_2/oe/ack.
REQ-016 Start edge and timeout in same cycle: start edge SHALL win (REQ-014), timeout_err not set.
REQ-017 Byte counter width SHALL be $clog2(max(NOS_WRITE_BYTES,NOS_READ_BYTES)+1); no wrap permitted.
REQ-018 Start-edge to first byte latch latency SHALL be ≤ 4 clk cycles after H1 becomes valid.

Reset
REQ-019 With reset=0 at a clk rising edge: state := S_IDLE; uP_handshake_2, uP_ack, uP_data_oe, rx_valid, timeout_err, busy := 0; uP_data_out, rx_packet, buffer := 0; synchronisers := 0.
REQ-020 Reset mid-transaction SHALL take effect at the next edge regardless of state, discarding partial data.

Structure
REQ-021 byte_t, the FSM state enum typedef and default constants NOS_WRITE_BYTES/NOS_READ_BYTES SHALL live in the shared types package/global constants.
REQ-022 One sub-module, synchroniser (2-flop, parametrised width), SHALL be instantiated for the three async inputs.

Verification
REQ-023 Write bytes 01,40,78,56,34,12 -> rx_valid one pulse, rx_packet = 48'h12345678_4001; supply tx_packet = 64'h0_000003E8 -> uP reads E8,03,00,00,00,00,00,00, then uP_ack = 1.
REQ-024 TIMEOUT_CYCLES = 64, H1 held high after byte 2 -> exactly 64 cycles later state S_IDLE, timeout_err = 1, handshake_2 = 0, no rx_valid.
REQ-025 Start edge after 3 bytes, then 6 new bytes AA..AF -> single rx_valid, rx_packet = 48'hAFAEADACABAA.
REQ-026 Instance NOS_WRITE_BYTES = 2, NOS_READ_BYTES = 4 -> rx_valid after 2nd byte, ack after exactly 4 read handshakes.
REQ-027 Reset low during S_TX_H1_HI -> next edge oe = 0, handshake_2 = 0, ack = 0, busy = 0.
REQ-028 RW = 1 during S_TX_H1_HI -> uP_data_oe = 0 throughout (no bus contention).
